// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link constants, state/word-class types and pattern helpers.
package tlk2711_pkg;

  localparam logic [7:0]  K28_5      = 8'hBC;
  localparam logic [7:0]  D5_6       = 8'hC5;
  localparam logic [7:0]  D11_5      = 8'hAB;
  localparam logic [15:0] COMMA_WORD = {D5_6, K28_5};
  localparam logic [15:0] SOF_WORD   = {D11_5, K28_5};

  // Transmit generator modes, shared with the TX pattern block.
  localparam logic [1:0] TX_MODE_IDLE     = 2'd0;
  localparam logic [1:0] TX_MODE_PATTERN  = 2'd1;
  localparam logic [1:0] TX_MODE_LOOPBACK = 2'd2;
  localparam logic [1:0] TX_MODE_KCODE    = 2'd3;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ALIGN = 2'd1,
    DATA  = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    WC_COMMA = 2'd0,
    WC_SOF   = 2'd1,
    WC_DATA  = 2'd2,
    WC_BAD   = 2'd3
  } word_class_t;

  // Classify one received word by its K flags and content.
  function automatic word_class_t classify(input logic [15:0] w, input logic [1:0] k);
    word_class_t c;
    c = WC_BAD;
    if (k == 2'b00)                          c = WC_DATA;
    else if (k == 2'b01 && w == COMMA_WORD)  c = WC_COMMA;
    else if (k == 2'b01 && w == SOF_WORD)    c = WC_SOF;
    return c;
  endfunction

  // Payload word n carries its index in both bytes.
  function automatic logic [15:0] exp_word(input logic [4:0] n);
    return {3'b000, n, 3'b000, n};
  endfunction

endpackage

// File: rtl/tlk2711_sat_counter.sv
// Saturating up-counter with synchronous clear that beats increment.
module tlk2711_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear first, otherwise increment until all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/tlk2711_rx_checker.sv
// TLK2711 receive frame checker: comma/SOF alignment, payload pattern check,
// lock tracking and saturating good-frame / word-error counters.
module tlk2711_rx_checker
  import tlk2711_pkg::*;
#(
  parameter int DATA_WORDS    = 32,
  parameter int LOCK_FRAMES   = 2,
  parameter int UNLOCK_FRAMES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_rxd,
  input  logic             i_rkmsb,
  input  logic             i_rklsb,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_frame_ok,
  output logic             o_word_err,
  output logic             o_lost_sync,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [1:0]       o_state
);

  localparam int IDX_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam int GR_W  = $clog2(LOCK_FRAMES + 1);
  localparam int BR_W  = $clog2(UNLOCK_FRAMES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WORDS - 1);
  localparam logic [GR_W-1:0]  LOCK_N   = GR_W'(LOCK_FRAMES);
  localparam logic [BR_W-1:0]  UNLOCK_N = BR_W'(UNLOCK_FRAMES);

  // ---- stage 1: pin register ----
  logic [15:0] rxd_p1_d, rxd_p1_q;
  logic [1:0]  rk_p1_d, rk_p1_q;

  // Capture the raw pins; data path needs no reset.
  always_comb begin
    rxd_p1_d = i_rxd;
    rk_p1_d  = {i_rkmsb, i_rklsb};
  end

  // Input register.
  always_ff @(posedge clk) begin
    rxd_p1_q <= rxd_p1_d;
    rk_p1_q  <= rk_p1_d;
  end

  // ---- stage 2: classify, compare, FSM and registered outputs ----
  rx_state_t        state_d, state_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             bad_d, bad_q;
  logic [GR_W-1:0]  good_run_d, good_run_q;
  logic [BR_W-1:0]  bad_run_d, bad_run_q;
  logic             locked_d, locked_q;
  logic             frame_ok_d, frame_ok_q;
  logic             word_err_d, word_err_q;
  logic             lost_sync_d, lost_sync_q;
  logic             frame_end, frame_good;
  word_class_t      wclass;

  // Framing FSM, payload compare and lock bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    locked_d    = locked_q;
    frame_ok_d  = 1'b0;
    word_err_d  = 1'b0;
    lost_sync_d = 1'b0;
    frame_end   = 1'b0;
    frame_good  = 1'b0;
    wclass      = classify(rxd_p1_q, rk_p1_q);

    case (state_q)
      HUNT: begin
        if (wclass == WC_COMMA) state_d = ALIGN;
      end
      ALIGN: begin
        if (wclass == WC_SOF) begin
          state_d = DATA;
          idx_d   = '0;
          bad_d   = 1'b0;
        end else if (wclass != WC_COMMA) begin
          // Idle or stopped transmitter: fall back quietly.
          state_d = HUNT;
        end
      end
      DATA: begin
        if (wclass == WC_COMMA) begin
          word_err_d = 1'b1;
          frame_end  = 1'b1;
          state_d    = ALIGN;
        end else if (wclass == WC_SOF) begin
          // Premature SOF aborts the current frame and opens a new one.
          frame_end = 1'b1;
          idx_d     = '0;
          bad_d     = 1'b0;
        end else begin
          word_err_d = (wclass == WC_BAD) || (rxd_p1_q != exp_word(5'(idx_q)));
          if (idx_q == LAST_IDX) begin
            frame_end  = 1'b1;
            frame_good = !(bad_q || word_err_d);
            state_d    = ALIGN;
          end else begin
            idx_d = idx_q + 1'b1;
            bad_d = bad_q | word_err_d;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (frame_end) begin
      if (frame_good) begin
        frame_ok_d = 1'b1;
        bad_run_d  = '0;
        if (good_run_q != LOCK_N) good_run_d = good_run_q + 1'b1;
        if (good_run_d == LOCK_N) locked_d = 1'b1;
      end else begin
        good_run_d = '0;
        if (bad_run_q != UNLOCK_N) bad_run_d = bad_run_q + 1'b1;
        if (locked_q && (bad_run_d == UNLOCK_N)) begin
          locked_d    = 1'b0;
          lost_sync_d = 1'b1;
          bad_run_d   = '0;
        end
      end
    end
  end

  // Control state and output pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      locked_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      word_err_q  <= 1'b0;
      lost_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bad_q       <= bad_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      locked_q    <= locked_d;
      frame_ok_q  <= frame_ok_d;
      word_err_q  <= word_err_d;
      lost_sync_q <= lost_sync_d;
    end
  end

  tlk2711_sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_clear),
    .inc   (frame_ok_d),
    .o_cnt (o_frame_cnt)
  );

  tlk2711_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_clear),
    .inc   (word_err_d),
    .o_cnt (o_err_cnt)
  );

  assign o_locked    = locked_q;
  assign o_frame_ok  = frame_ok_q;
  assign o_word_err  = word_err_q;
  assign o_lost_sync = lost_sync_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// Randomized frame-level bench for tlk2711_rx_checker with a frame-level model.
module tb_tlk2711_rx_checker;
  import tlk2711_pkg::*;

  localparam int NW     = 32;
  localparam int LOCK   = 2;
  localparam int UNLOCK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_rxd;
  logic        i_rkmsb, i_rklsb, i_clear;
  logic        o_locked, o_frame_ok, o_word_err, o_lost_sync;
  logic [31:0] o_frame_cnt, o_err_cnt;
  logic [1:0]  o_state;
  logic        o4_locked, o4_frame_ok, o4_word_err, o4_lost_sync;
  logic [3:0]  o4_frame_cnt, o4_err_cnt;
  logic [1:0]  o4_state;

  always #5 clk = ~clk;

  tlk2711_rx_checker u_dut (
    .clk(clk), .rst(rst), .i_rxd(i_rxd), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb),
    .i_clear(i_clear), .o_locked(o_locked), .o_frame_ok(o_frame_ok),
    .o_word_err(o_word_err), .o_lost_sync(o_lost_sync), .o_frame_cnt(o_frame_cnt),
    .o_err_cnt(o_err_cnt), .o_state(o_state)
  );

  tlk2711_rx_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_rxd(i_rxd), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb),
    .i_clear(i_clear), .o_locked(o4_locked), .o_frame_ok(o4_frame_ok),
    .o_word_err(o4_word_err), .o_lost_sync(o4_lost_sync), .o_frame_cnt(o4_frame_cnt),
    .o_err_cnt(o4_err_cnt), .o_state(o4_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observed pulse totals.
  int mon_ok = 0, mon_err = 0, mon_lost = 0;
  always @(posedge clk) begin
    #1;
    if (o_frame_ok)  mon_ok++;
    if (o_word_err)  mon_err++;
    if (o_lost_sync) mon_lost++;
  end

  // Frame-level reference model.
  int m_ok = 0, m_err = 0, m_lost = 0;
  int m_fcnt = 0, m_ecnt = 0;
  int m_good_run = 0, m_bad_run = 0;
  bit m_locked = 0;

  function automatic logic [15:0] exp_w(input int n);
    logic [4:0] n5;
    n5 = 5'(n);
    return {3'b000, n5, 3'b000, n5};
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic model_frame(input bit good);
    if (good) begin
      m_ok++; m_fcnt++; m_bad_run = 0; m_good_run++;
      if (m_good_run >= LOCK) m_locked = 1;
    end else begin
      m_good_run = 0; m_bad_run++;
      if (m_locked && m_bad_run >= UNLOCK) begin
        m_locked = 0; m_lost++; m_bad_run = 0;
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic [1:0] k);
    @(negedge clk);
    i_rxd = w;
    {i_rkmsb, i_rklsb} = k;
  endtask

  task automatic corrupt(input logic [15:0] w, output logic [15:0] cw, output logic [1:0] ck);
    if ($urandom_range(0, 3) == 0) begin
      cw = w;
      ck = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
    end else begin
      cw = w ^ 16'($urandom_range(1, 65535));
      ck = 2'b00;
    end
  endtask

  // Send 2 commas, SOF and a full payload with the words in mask corrupted,
  // then flush with commas and compare everything against the model.
  task automatic send_frame(input logic [31:0] mask, input bit use_fix,
                            input logic [15:0] fixval, input int clr_at);
    int nbad;
    logic [15:0] w;
    logic [1:0] k;
    nbad = $countones(mask);
    send_word(COMMA_WORD, 2'b01);
    send_word(COMMA_WORD, 2'b01);
    send_word(SOF_WORD, 2'b01);
    for (int n = 0; n < NW; n++) begin
      w = exp_w(n); k = 2'b00;
      if (mask[n]) begin
        if (use_fix) w = fixval;
        else corrupt(exp_w(n), w, k);
      end
      send_word(w, k);
      i_clear = (clr_at >= 0 && n == clr_at + 1);
      if (clr_at >= 0 && n == clr_at + 2) begin
        n_checks++;
        if (o_word_err !== mask[clr_at]) $display("FAIL clr_word_err: got %0b want %0b", o_word_err, mask[clr_at]);
        else n_pass++;
        n_checks++;
        if (o_err_cnt !== 32'd0 || o4_err_cnt !== 4'd0) $display("FAIL clr_beats_inc: got %0d/%0d want 0", o_err_cnt, o4_err_cnt);
        else n_pass++;
        n_checks++;
        if (o_frame_cnt !== 32'd0 || o4_frame_cnt !== 4'd0) $display("FAIL clr_frame_cnt: got %0d/%0d want 0", o_frame_cnt, o4_frame_cnt);
        else n_pass++;
      end
    end
    m_err += nbad;
    if (clr_at >= 0) begin
      m_ecnt = $countones(mask >> (clr_at + 1));
      m_fcnt = 0;
    end else begin
      m_ecnt += nbad;
    end
    model_frame(nbad == 0);
    send_word(COMMA_WORD, 2'b01);
    n_checks++;
    if (o_frame_ok !== 1'b0) $display("FAIL frame_ok_early: got %0b want 0", o_frame_ok);
    else n_pass++;
    send_word(COMMA_WORD, 2'b01);
    n_checks++;
    if (o_frame_ok !== (nbad == 0)) $display("FAIL frame_ok_t2: got %0b want %0b", o_frame_ok, (nbad == 0));
    else n_pass++;
    n_checks++;
    if (o_locked !== m_locked || o4_locked !== m_locked) $display("FAIL locked: got %0b want %0b", o_locked, m_locked);
    else n_pass++;
    n_checks++;
    if (o_frame_cnt !== 32'(m_fcnt)) $display("FAIL frame_cnt: got %0d want %0d", o_frame_cnt, m_fcnt);
    else n_pass++;
    send_word(COMMA_WORD, 2'b01);
    n_checks++;
    if (o_err_cnt !== 32'(m_ecnt)) $display("FAIL err_cnt: got %0d want %0d", o_err_cnt, m_ecnt);
    else n_pass++;
    n_checks++;
    if (o4_err_cnt !== sat4(m_ecnt) || o4_frame_cnt !== sat4(m_fcnt))
      $display("FAIL cnt4: got err %0h frm %0h want err %0h frm %0h", o4_err_cnt, o4_frame_cnt, sat4(m_ecnt), sat4(m_fcnt));
    else n_pass++;
    n_checks++;
    if (mon_ok !== m_ok || mon_err !== m_err || mon_lost !== m_lost)
      $display("FAIL pulses: got ok %0d err %0d lost %0d want %0d %0d %0d", mon_ok, mon_err, mon_lost, m_ok, m_err, m_lost);
    else n_pass++;
    n_checks++;
    if (o_state !== 2'd1) $display("FAIL state_after_frame: got %0d want 1", o_state);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_clear = 1'b0; i_rxd = COMMA_WORD; {i_rkmsb, i_rklsb} = 2'b01;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_locked, o_frame_ok, o_word_err, o_lost_sync} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {o_locked, o_frame_ok, o_word_err, o_lost_sync});
    else n_pass++;
    n_checks++;
    if (o_frame_cnt !== 32'd0 || o_err_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d %0d want 0 0", o_frame_cnt, o_err_cnt);
    else n_pass++;
    n_checks++;
    if (o_state !== 2'd0 || o4_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", o_state);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_lock();
    for (int f = 0; f < 3; f++) send_frame(32'h0, 1'b0, 16'h0, -1);
  endtask

  task automatic test_single_err();
    send_frame(32'h1 << 5, 1'b1, 16'h0506, -1);
  endtask

  task automatic test_unlock();
    send_frame(32'h0, 1'b0, 16'h0, -1);
    for (int f = 0; f < 4; f++) send_frame(32'h1 << $urandom_range(0, NW - 1), 1'b0, 16'h0, -1);
    for (int f = 0; f < 2; f++) send_frame(32'h0, 1'b0, 16'h0, -1);
  endtask

  task automatic test_abort_comma();
    send_word(COMMA_WORD, 2'b01);
    send_word(SOF_WORD, 2'b01);
    for (int n = 0; n < 10; n++) send_word(exp_w(n), 2'b00);
    send_word(COMMA_WORD, 2'b01);
    m_err++; m_ecnt++;
    model_frame(1'b0);
    send_word(COMMA_WORD, 2'b01);
    send_word(COMMA_WORD, 2'b01);
    n_checks++;
    if (o_word_err !== 1'b1) $display("FAIL abort_word_err: got %0b want 1", o_word_err);
    else n_pass++;
    n_checks++;
    if (o_state !== 2'd1) $display("FAIL abort_state: got %0d want 1", o_state);
    else n_pass++;
    send_frame(32'h0, 1'b0, 16'h0, -1);
  endtask

  task automatic test_comma_stream();
    repeat (1000) send_word(COMMA_WORD, 2'b01);
    n_checks++;
    if (o_state !== 2'd1) $display("FAIL stream_state: got %0d want 1", o_state);
    else n_pass++;
    repeat (3) send_word(16'h0000, 2'b00);
    n_checks++;
    if (o_state !== 2'd0) $display("FAIL stream_hunt: got %0d want 0", o_state);
    else n_pass++;
    n_checks++;
    if (mon_err !== m_err || mon_ok !== m_ok || o_err_cnt !== 32'(m_ecnt) || o_frame_cnt !== 32'(m_fcnt))
      $display("FAIL stream_quiet: got err %0d ok %0d want %0d %0d", mon_err, mon_ok, m_err, m_ok);
    else n_pass++;
    n_checks++;
    if (o_locked !== m_locked) $display("FAIL stream_lock: got %0b want %0b", o_locked, m_locked);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] mask;
    for (int f = 0; f < 12; f++) begin
      mask = 32'h0;
      if ($urandom_range(0, 2) == 0)
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) mask[$urandom_range(0, NW - 1)] = 1'b1;
      send_frame(mask, 1'b0, 16'h0, -1);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] mask;
    while (m_fcnt <= 16) send_frame(32'h0, 1'b0, 16'h0, -1);
    mask = 32'h000F_FFFF;
    send_frame(mask, 1'b0, 16'h0, -1);
    send_frame(32'h1, 1'b1, 16'h1234, 0);
    send_frame(32'h0, 1'b0, 16'h0, -1);
    @(negedge clk); i_clear = 1'b1;
    @(negedge clk); i_clear = 1'b0;
    m_fcnt = 0; m_ecnt = 0;
    n_checks++;
    if (o_frame_cnt !== 32'd0 || o_err_cnt !== 32'd0 || o4_frame_cnt !== 4'd0) $display("FAIL idle_clear: got %0d %0d want 0 0", o_frame_cnt, o_err_cnt);
    else n_pass++;
    n_checks++;
    if (o_locked !== m_locked) $display("FAIL clear_keeps_lock: got %0b want %0b", o_locked, m_locked);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    send_word(COMMA_WORD, 2'b01);
    send_word(SOF_WORD, 2'b01);
    for (int n = 0; n < 10; n++) send_word(exp_w(n), 2'b00);
    @(negedge clk);
    rst = 1'b1; i_rxd = COMMA_WORD; {i_rkmsb, i_rklsb} = 2'b01;
    repeat (2) @(negedge clk);
    m_fcnt = 0; m_ecnt = 0; m_locked = 0; m_good_run = 0; m_bad_run = 0;
    n_checks++;
    if (o_state !== 2'd0 || o_locked !== 1'b0 || o_frame_cnt !== 32'd0 || o_err_cnt !== 32'd0)
      $display("FAIL midframe_reset: got st %0d lk %0b fc %0d ec %0d want 0", o_state, o_locked, o_frame_cnt, o_err_cnt);
    else n_pass++;
    rst = 1'b0;
    send_frame(32'h0, 1'b0, 16'h0, -1);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_unlock();
    test_abort_comma();
    test_comma_stream();
    test_random();
    test_saturation();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlk2711_rx_checker.md
Name: tlk2711_rx_checker

Overview:
- Receive-side frame checker for the TLK2711 serial link. It consumes the deserialized 16-bit words and K flags that correspond to the transmit test-pattern generator's output.
- Aligns to the comma/SOF framing, checks every payload word against the expected incrementing pattern, and counts good frames and word errors.
- Reports link lock status to software/ILA.
- Sits directly on the TLK2711 RX pins, clocked by the receive clock.

Parameters:
- DATA_WORDS, 32: payload words per frame; expected index width is clog2(DATA_WORDS).
- LOCK_FRAMES, 2: consecutive error-free frames required to assert lock.
- UNLOCK_FRAMES, 4: consecutive errored frames required to drop lock.
- CNT_W, 32: width of the frame and error counters.

Ports:
- clk  in  1  receive clock; all logic in this domain
- rst  in  1  synchronous, active-high reset
- i_rxd  in  16  received word; [15:8] msb byte, [7:0] lsb byte
- i_rkmsb  in  1  msb byte is a K character
- i_rklsb  in  1  lsb byte is a K character
- i_clear  in  1  synchronous clear of o_frame_cnt and o_err_cnt
- o_locked  out  1  link locked to framing
- o_frame_ok  out  1  one-cycle pulse per error-free frame
- o_word_err  out  1  one-cycle pulse per erroneous word
- o_lost_sync  out  1  one-cycle pulse when lock drops
- o_frame_cnt  out  CNT_W  good frames received, saturating
- o_err_cnt  out  CNT_W  word errors, saturating
- o_state  out  2  current FSM state (debug)

Behaviour:
- Reset: all outputs 0; state HUNT; internal run counters 0.
- Word classes are computed from the input register:
  - COMMA = K flags {msb,lsb}=01 and word 16'hC5BC (D5.6, K28.5).
  - SOF = K flags 01 and word 16'hABBC (D11.5, K28.5).
  - DATA = K flags 00.
  - BAD = anything else.
- Expected payload word n (n = 0..DATA_WORDS-1) is {3'b0,n[4:0],3'b0,n[4:0]}: first word 16'h0000, last 16'h1F1F.
- FSM transitions:
  - HUNT: COMMA -> ALIGN; anything else stays in HUNT, no error counted.
  - ALIGN: COMMA stays. SOF -> DATA with idx=0 and the frame-bad flag cleared. DATA or BAD -> HUNT with no error counted (covers transmitter idle or stopped).
  - DATA: compare the word with expected(idx). A mismatch, a BAD word, or a COMMA sets frame-bad and pulses o_word_err.
    - COMMA inside a frame: terminate the frame as errored and go to ALIGN.
    - SOF inside a frame: terminate the frame as errored and restart DATA with idx=0.
    - When idx==DATA_WORDS-1: the frame ends and the FSM goes to ALIGN.
- Frame end, good: pulse o_frame_ok, increment o_frame_cnt, good_run++ (saturating), bad_run=0. o_locked is set when good_run reaches LOCK_FRAMES.
- Frame end, errored: good_run=0, bad_run++. If o_locked and bad_run reaches UNLOCK_FRAMES: clear o_locked, pulse o_lost_sync, bad_run=0.
- o_err_cnt increments once per erroneous word. Each increment is exactly one o_word_err pulse.
- Latency: inputs are registered once (stage 1); classify, compare and outputs are registered (stage 2). A word present at the pins in cycle t produces o_word_err, o_frame_ok and counter updates in cycle t+2.
- Counters saturate at all-ones with no wrap. i_clear zeroes both counters next cycle; clear beats a simultaneous increment. i_clear does not affect the FSM or o_locked.
- Reset mid-frame: immediate return to reset values; the partial frame is not counted.
- A continuous COMMA stream (loopback/K-code modes) holds the FSM in ALIGN with no errors and no lock change.

Decomposition:
- tlk2711_pkg holds:
  - K28_5 8'hBC, D5_6 8'hC5, D11_5 8'hAB
  - COMMA_WORD 16'hC5BC, SOF_WORD 16'hABBC
  - rx_state_t enum {HUNT=0, ALIGN=1, DATA=2}
  - The TX mode constants, moved into the package so both blocks share them.
- Sub-module tlk2711_sat_counter (param W; inputs clr, inc; saturating) is instantiated for o_frame_cnt and o_err_cnt.

Test Plan:
- 2 COMMA, SOF, payload 0x0000..0x1F1F, repeated 3 times -> o_frame_ok pulses 3 times, o_frame_cnt=3, o_err_cnt=0, o_locked=1 at t+2 after the last word of frame 2.
- Locked link; payload word 5 corrupted to 16'h0506 in one frame -> single o_word_err, o_err_cnt=1, no o_frame_ok for that frame, o_locked stays 1.
- Locked link; 4 consecutive frames each with one bad word -> o_err_cnt=4, o_lost_sync one pulse, o_locked=0; then 2 clean frames -> o_locked=1.
- SOF, 10 payload words, then COMMA -> o_word_err once, FSM returns to ALIGN; the next full frame counts good.
- 1000 cycles of 16'hC5BC with K=01, then 16'h0000 with K=00 -> no errors, no frames; FSM ends in HUNT.
- o_err_cnt forced near saturation (CNT_W=4 build) with extra errors -> holds 4'hF. i_clear asserted in the same cycle as an error -> counter reads 0.
